// File: rtl/sequence_decoder.sv
// Decodes the 40-bit reseed word embedded in one line of an interleaved Cr Y Cb Y
// stream: luma majority voting per bit, chroma sanity checking, identifier match.
module sequence_decoder #(
   parameter logic [9:0]  THRESHOLD      = 10'h1F6,
   parameter logic [9:0]  CHROMA_NEUTRAL = 10'h200,
   parameter logic [9:0]  CHROMA_TOL     = 10'h040,
   parameter logic [7:0]  EXPECTED_ID    = 8'hA5,
   parameter int unsigned ALIGN_OFFSET   = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [9:0]  sample_in,
   output logic [31:0] reseed_count,
   output logic        reseed_valid,
   output logic        id_error,
   output logic        format_error,
   output logic        abort,
   output logic        busy
);

   localparam logic [5:0] LAST_SAMPLE = 6'd35;  // 36 samples (18 luma) per bit
   localparam logic [5:0] LAST_BIT    = 6'd39;  // 40 bits per word
   localparam logic [4:0] VOTE_MIN    = 5'd10;  // luma votes needed for a 1
   localparam int         SKIP_W      = (ALIGN_OFFSET > 1) ? $clog2(ALIGN_OFFSET) : 1;
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(ALIGN_OFFSET - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SKIP,
      S_COLLECT,
      S_REPORT,
      S_WAIT_LOW
   } state_e;

   state_e              state_q, state_d;
   logic                en_q;
   logic                armed_q, armed_d;
   logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
   logic [5:0]          sample_cnt_q, sample_cnt_d;
   logic [5:0]          bit_cnt_q, bit_cnt_d;
   logic [4:0]          vote_q, vote_d;
   logic [39:0]         word_q, word_d;
   logic                viol_q, viol_d;
   logic [31:0]         reseed_count_q, reseed_count_d;
   logic                reseed_valid_q, reseed_valid_d;
   logic                id_error_q, id_error_d;
   logic                format_error_q, format_error_d;
   logic                abort_q, abort_d;

   logic                rise;
   logic                is_luma;
   logic                luma_hit;
   logic [9:0]          chroma_dev;
   logic                chroma_bad;
   logic [4:0]          vote_sum;
   logic                bit_value;
   logic                start_collect;

   // armed_q only sets once enable has been seen low after reset, so a line
   // already in progress when reset drops cannot be mistaken for a new one.
   assign rise       = enable && !en_q && armed_q;
   assign armed_d    = !enable;

   assign is_luma    = sample_cnt_q[0];
   assign luma_hit   = is_luma && (sample_in > THRESHOLD);
   assign chroma_dev = (sample_in >= CHROMA_NEUTRAL) ? (sample_in - CHROMA_NEUTRAL)
                                                     : (CHROMA_NEUTRAL - sample_in);
   assign chroma_bad = !is_luma && (chroma_dev > CHROMA_TOL);
   assign vote_sum   = vote_q + {4'd0, luma_hit};
   assign bit_value  = (vote_sum >= VOTE_MIN);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d        = state_q;
      skip_cnt_d     = skip_cnt_q;
      sample_cnt_d   = sample_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      vote_d         = vote_q;
      word_d         = word_q;
      viol_d         = viol_q;
      reseed_count_d = reseed_count_q;
      reseed_valid_d = 1'b0;
      id_error_d     = 1'b0;
      format_error_d = 1'b0;
      abort_d        = 1'b0;
      start_collect  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               if (ALIGN_OFFSET == 0) begin
                  start_collect = 1'b1;
               end else begin
                  state_d    = S_SKIP;
                  skip_cnt_d = '0;
               end
            end
         end

         S_SKIP: begin
            if (!enable) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else if (skip_cnt_q == SKIP_LAST) begin
               start_collect = 1'b1;
            end else begin
               skip_cnt_d = skip_cnt_q + SKIP_W'(1);
            end
         end

         S_COLLECT: begin
            // A sample only counts when enable is high, including the very last one.
            if (!enable) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               viol_d = viol_q || chroma_bad;
               if (sample_cnt_q == LAST_SAMPLE) begin
                  word_d       = {word_q[38:0], bit_value};
                  sample_cnt_d = '0;
                  vote_d       = '0;
                  bit_cnt_d    = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = S_REPORT;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + 6'd1;
                  vote_d       = vote_sum;
               end
            end
         end

         S_REPORT: begin
            if (viol_q) begin
               format_error_d = 1'b1;
            end else if (word_q[39:32] != EXPECTED_ID) begin
               id_error_d = 1'b1;
            end else begin
               reseed_count_d = word_q[31:0];
               reseed_valid_d = 1'b1;
            end
            state_d = enable ? S_WAIT_LOW : S_IDLE;
         end

         S_WAIT_LOW: begin
            if (!enable) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (start_collect) begin
         state_d      = S_COLLECT;
         sample_cnt_d = '0;
         bit_cnt_d    = '0;
         vote_d       = '0;
         word_d       = '0;
         viol_d       = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         en_q           <= 1'b0;
         armed_q        <= 1'b0;
         skip_cnt_q     <= '0;
         sample_cnt_q   <= '0;
         bit_cnt_q      <= '0;
         vote_q         <= '0;
         word_q         <= '0;
         viol_q         <= 1'b0;
         reseed_count_q <= '0;
         reseed_valid_q <= 1'b0;
         id_error_q     <= 1'b0;
         format_error_q <= 1'b0;
         abort_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         en_q           <= enable;
         armed_q        <= armed_d;
         skip_cnt_q     <= skip_cnt_d;
         sample_cnt_q   <= sample_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         vote_q         <= vote_d;
         word_q         <= word_d;
         viol_q         <= viol_d;
         reseed_count_q <= reseed_count_d;
         reseed_valid_q <= reseed_valid_d;
         id_error_q     <= id_error_d;
         format_error_q <= format_error_d;
         abort_q        <= abort_d;
      end
   end

   assign reseed_count = reseed_count_q;
   assign reseed_valid = reseed_valid_q;
   assign id_error     = id_error_q;
   assign format_error = format_error_q;
   assign abort        = abort_q;
   assign busy         = (state_q == S_SKIP) || (state_q == S_COLLECT);

endmodule

// File: doc/sequence_decoder.md
SEQUENCE_DECODER -- requirements
Module: sequence_decoder

Interface
REQ-001 Parameter THRESHOLD, default 10'h1F6, luma slicing level; sample > THRESHOLD reads as bit 1.
REQ-002 Parameter CHROMA_NEUTRAL, default 10'h200, expected value of every chroma sample.
REQ-003 Parameter CHROMA_TOL, default 10'h040, allowed absolute deviation of chroma from CHROMA_NEUTRAL.
REQ-004 Parameter EXPECTED_ID, default 8'hA5, identifier required in bits [39:32] of the received word.
REQ-005 Parameter ALIGN_OFFSET, default 0, samples discarded after the enable rising edge before collection starts.
REQ-006 clock  input  1  single clock, one sample per cycle, 1440 samples per line.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  high during the embedded sequence line window.
REQ-009 sample_in  input  10  interleaved Cr Y Cb Y stream, 10-bit BT.601 code.
REQ-010 reseed_count  output  32  last accepted reseed count, held between updates.
REQ-011 reseed_valid  output  1  one-cycle pulse when reseed_count is updated.
REQ-012 id_error  output  1  one-cycle pulse, complete word received with wrong identifier.
REQ-013 format_error  output  1  one-cycle pulse, complete word discarded for chroma violation.
REQ-014 abort  output  1  one-cycle pulse, enable fell before 40 bits were collected.
REQ-015 busy  output  1  high in SKIP and COLLECT.

Function
REQ-016 States SHALL be IDLE, SKIP, COLLECT, REPORT, WAIT_LOW.
REQ-017 IDLE -> SKIP on enable rising edge (enable high, registered previous enable low); goes directly to COLLECT when ALIGN_OFFSET = 0.
REQ-018 SKIP SHALL discard exactly ALIGN_OFFSET samples, then enter COLLECT.
REQ-019 In COLLECT, sample index n (0-based from first collected sample) SHALL be chroma when n even, luma when n odd.
REQ-020 Bit k SHALL span samples 36k..36k+35 (18 luma samples); decoded bit = 1 if at least 10 luma samples exceed THRESHOLD, else 0 (9 = 0).
REQ-021 Bits SHALL be received MSB first: bit 0 of the stream is word bit 39.
REQ-022 Vote counter 5 bits, sample counter 6 bits wrapping at 35, bit counter 6 bits, 40-bit shift register.
REQ-023 Any chroma sample with |sample_in - CHROMA_NEUTRAL| > CHROMA_TOL SHALL set a sticky violation flag, cleared on entering COLLECT.
REQ-024 After sample 1439 is consumed, the next state SHALL be REPORT; REPORT lasts exactly one cycle.
REQ-025 REPORT priority: violation -> format_error; else id mismatch -> id_error; else reseed_count <= word[31:0] and reseed_valid.
REQ-026 All pulses SHALL be registered and asserted in the cycle after REPORT is entered (latency: 2 cycles after last sample), exactly one cycle wide.
REQ-027 enable low in SKIP or COLLECT SHALL pulse abort, discard the partial word, return to IDLE; reseed_count unchanged.
REQ-028 enable low in the same cycle as sample 1439 SHALL count as abort (sample requires enable high).
REQ-029 After REPORT, if enable high -> WAIT_LOW; remains until enable low, then IDLE; no restart without a new rising edge.
REQ-030 At most one of reseed_valid, id_error, format_error, abort SHALL be high in any cycle.

Reset
REQ-031 reset SHALL force IDLE, clear all counters, shift register, violation flag, registered enable, and drive reseed_count = 0, all pulses = 0, busy = 0.
REQ-032 reset mid-COLLECT SHALL discard the partial word without abort pulse; an enable held high after reset SHALL NOT start collection until it falls and rises again.

Verification
REQ-033 Ideal line, word {8'hA5, 32'h12345678}, white 10'h3AC / black 10'h040, chroma 10'h200 -> reseed_count = 32'h12345678, single reseed_valid 2 cycles after sample 1439.
REQ-034 Same line with id 8'h5A -> id_error pulse once, reseed_count keeps prior value.
REQ-035 Bit value 1 with 8 of 18 luma samples forced to 10'h040 -> decoded 1; with 9 forced -> decoded 0.
REQ-036 enable dropped at sample 700 -> abort pulse, busy low next cycle, no reseed_valid.
REQ-037 One chroma sample 10'h300 (tolerance 10'h040) -> format_error only, even with correct id.
REQ-038 reset asserted at sample 500 with enable held high -> all outputs 0, no activity until enable low-then-high, next ideal line decodes correctly.
